// File: rtl/fifo_byte_serializer_if.sv
// fifo_byte_serializer_if
//   Bundles the FIFO read side and the byte-stream side of the serializer.
//   master : the serializer (pops the FIFO, drives the byte stream).
//   slave  : the environment (FIFO + byte sink).
//
//   FIFO side : fifo_re is a one-cycle read strobe; fifo_data is the FIFO's
//               registered output and is valid the cycle after the strobe;
//               fifo_empty says whether a read is allowed.
//   Byte side : a byte transfers on a rising edge where tx_valid && tx_ready.
//               Once tx_valid is high, tx_data/tx_last stay stable until that
//               transfer. tx_ready is ignored while tx_valid is low.
//   Status    : busy (not idle) and word_count (words fully sent, wrapping).
interface fifo_byte_serializer_if #(
    parameter int CNT_W = 16
);
    logic             fifo_empty;
    logic [31:0]      fifo_data;
    logic             fifo_re;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             tx_last;
    logic             busy;
    logic [CNT_W-1:0] word_count;

    modport master (
        input  fifo_empty, fifo_data, tx_ready,
        output fifo_re, tx_data, tx_valid, tx_last, busy, word_count
    );

    modport slave (
        output fifo_empty, fifo_data, tx_ready,
        input  fifo_re, tx_data, tx_valid, tx_last, busy, word_count
    );
endinterface

// File: rtl/fifo_byte_serializer.sv
// fifo_byte_serializer
//   Pops 32-bit words from a synchronous FIFO and sends each one as four
//   bytes on a valid/ready stream, marking the 4th byte with tx_last and
//   counting completed words.
// Ports:
//   clk       : rising-edge clock
//   reset     : asynchronous, active-high reset
//   bus       : fifo_byte_serializer_if.master (FIFO read side, byte stream,
//               busy, word_count)
//   dbg_state : current FSM state (0 IDLE, 1 READ, 2 CAPTURE, 3 SEND)
// Every output is a flop; nothing combinational reaches an output.
module fifo_byte_serializer #(
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    fifo_byte_serializer_if.master        bus,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        CAPTURE = 2'd2,
        SEND    = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic             fifo_re_q, fifo_re_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             tx_last_q, tx_last_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;
    logic [1:0]       idx_q, idx_d;
    logic [31:0]      shift_q, shift_d;

    always_comb begin
        state_d      = state_q;
        fifo_re_d    = 1'b0;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        tx_last_d    = tx_last_q;
        busy_d       = busy_q;
        word_count_d = word_count_q;
        idx_d        = idx_q;
        shift_d      = shift_q;

        case (state_q)
            IDLE: begin
                // The strobe is registered, so it is raised on the way into
                // READ and is high for exactly the READ cycle.
                if (!bus.fifo_empty) begin
                    state_d   = READ;
                    fifo_re_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            READ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                shift_d    = bus.fifo_data;
                idx_d      = 2'd0;
                tx_valid_d = 1'b1;
                tx_last_d  = 1'b0;
                tx_data_d  = BIG_ENDIAN ? bus.fifo_data[31:24] : bus.fifo_data[7:0];
                state_d    = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (idx_q != 2'd3) begin
                        // The byte on tx_data is always the edge byte of
                        // shift_q; the next one sits right beside it.
                        idx_d     = idx_q + 2'd1;
                        shift_d   = BIG_ENDIAN ? (shift_q << 8) : (shift_q >> 8);
                        tx_data_d = BIG_ENDIAN ? shift_q[23:16] : shift_q[15:8];
                        tx_last_d = (idx_q == 2'd2);
                    end else begin
                        tx_valid_d   = 1'b0;
                        tx_last_d    = 1'b0;
                        idx_d        = 2'd0;
                        busy_d       = 1'b0;
                        word_count_d = word_count_q + CNT_W'(1);
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fifo_re_q    <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            tx_last_q    <= 1'b0;
            busy_q       <= 1'b0;
            word_count_q <= '0;
            idx_q        <= 2'd0;
            shift_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            fifo_re_q    <= fifo_re_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            tx_last_q    <= tx_last_d;
            busy_q       <= busy_d;
            word_count_q <= word_count_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
        end
    end

    assign bus.fifo_re    = fifo_re_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.tx_last    = tx_last_q;
    assign bus.busy       = busy_q;
    assign bus.word_count = word_count_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb_fifo_byte_serializer
//   Drives one little-endian and one big-endian serializer from small FIFO
//   models and checks the byte streams against hand-computed expectations.
module tb_fifo_byte_serializer;

    logic clk = 1'b0;
    logic reset;
    logic tx_ready;

    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.CNT_W(16)) bus_le ();
    fifo_byte_serializer_if #(.CNT_W(16)) bus_be ();
    logic [1:0] dbg_le, dbg_be;

    fifo_byte_serializer #(.BIG_ENDIAN(1'b0), .CNT_W(16)) dut_le (
        .clk(clk), .reset(reset), .bus(bus_le), .dbg_state(dbg_le)
    );
    fifo_byte_serializer #(.BIG_ENDIAN(1'b1), .CNT_W(16)) dut_be (
        .clk(clk), .reset(reset), .bus(bus_be), .dbg_state(dbg_be)
    );

    // ---------------- FIFO models (registered read data) ----------------
    logic [31:0] mem_le [16];
    logic [31:0] mem_be [16];
    logic [3:0]  wp_le = 4'd0, rp_le = 4'd0;
    logic [3:0]  wp_be = 4'd0, rp_be = 4'd0;
    int          bad_re = 0;

    assign bus_le.fifo_empty = (wp_le == rp_le);
    assign bus_be.fifo_empty = (wp_be == rp_be);
    assign bus_le.tx_ready   = tx_ready;
    assign bus_be.tx_ready   = tx_ready;

    always @(posedge clk) begin
        if (bus_le.fifo_re === 1'b1) begin
            if (bus_le.fifo_empty) bad_re <= bad_re + 1;
            else begin
                bus_le.fifo_data <= mem_le[rp_le];
                rp_le <= rp_le + 4'd1;
            end
        end
        if (bus_be.fifo_re === 1'b1) begin
            if (bus_be.fifo_empty) bad_re <= bad_re + 1;
            else begin
                bus_be.fifo_data <= mem_be[rp_be];
                rp_be <= rp_be + 4'd1;
            end
        end
    end

    // ---------------- monitor mux ----------------
    logic       sel;
    logic       mon_valid, mon_last, mon_re;
    logic [7:0] mon_data;
    assign mon_valid = sel ? bus_be.tx_valid : bus_le.tx_valid;
    assign mon_last  = sel ? bus_be.tx_last  : bus_le.tx_last;
    assign mon_re    = sel ? bus_be.fifo_re  : bus_le.fifo_re;
    assign mon_data  = sel ? bus_be.tx_data  : bus_le.tx_data;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       last_q[$];
    int         re_cyc_q[$];
    int         first_v;
    int         stall_err;
    bit         ready_pat[8];
    int         ready_len;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_le(input logic [31:0] w);
        mem_le[wp_le] = w;
        wp_le = wp_le + 4'd1;
    endtask

    task automatic push_be(input logic [31:0] w);
        mem_be[wp_be] = w;
        wp_be = wp_be + 4'd1;
    endtask

    task automatic set_ready_all();
        ready_pat[0] = 1'b1;
        ready_len    = 1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs the selected DUT until n_bytes handshakes or max_cyc cycles,
    // logging bytes, tx_last, fifo_re cycles and any change while stalled.
    task automatic run_bytes(input int n_bytes, input int max_cyc);
        logic [7:0] pd;
        logic       pl;
        bit         stalled;
        got_q.delete();
        last_q.delete();
        re_cyc_q.delete();
        stall_err = 0;
        first_v   = -1;
        stalled   = 1'b0;
        pd        = 8'h00;
        pl        = 1'b0;
        for (int c = 0; c < max_cyc && got_q.size() < n_bytes; c++) begin
            if (stalled && (mon_data !== pd || mon_last !== pl)) stall_err++;
            if (mon_re === 1'b1) re_cyc_q.push_back(c);
            if (mon_valid === 1'b1 && first_v < 0) first_v = c;
            tx_ready = ready_pat[c % ready_len];
            stalled  = 1'b0;
            if (mon_valid === 1'b1) begin
                if (tx_ready) begin
                    got_q.push_back(mon_data);
                    last_q.push_back(mon_last);
                end else begin
                    stalled = 1'b1;
                    pd      = mon_data;
                    pl      = mon_last;
                end
            end
            step();
        end
        tx_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b1;
        tx_ready = 1'b0;
        sel      = 1'b0;
        step();
        step();
        n_checks++;
        if ({bus_le.tx_valid, bus_le.tx_last, bus_le.busy, bus_le.fifo_re} !== 4'b0000)
            $display("FAIL reset_le_flags: got %b expected 0000",
                     {bus_le.tx_valid, bus_le.tx_last, bus_le.busy, bus_le.fifo_re});
        else n_pass++;
        n_checks++;
        if (bus_le.tx_data !== 8'h00 || bus_le.word_count !== 16'd0)
            $display("FAIL reset_le_data: got data %h count %0d expected 00 / 0",
                     bus_le.tx_data, bus_le.word_count);
        else n_pass++;
        n_checks++;
        if ({bus_be.tx_valid, bus_be.busy, bus_be.fifo_re} !== 3'b000 || bus_be.word_count !== 16'd0)
            $display("FAIL reset_be: got flags %b count %0d expected 000 / 0",
                     {bus_be.tx_valid, bus_be.busy, bus_be.fifo_re}, bus_be.word_count);
        else n_pass++;
        reset = 1'b0;
        step();
        n_checks++;
        if (dbg_le !== 2'd0 || dbg_be !== 2'd0)
            $display("FAIL reset_state: got le %0d be %0d expected 0/0", dbg_le, dbg_be);
        else n_pass++;
    endtask

    task automatic test_single_le();
        sel = 1'b0;
        set_ready_all();
        push_le(32'h11223344);
        exp_q = '{8'h44, 8'h33, 8'h22, 8'h11};
        run_bytes(4, 40);
        n_checks++;
        if (got_q.size() !== 4) $display("FAIL le_nbytes: got %0d expected 4", got_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3))
                $display("FAIL le_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (re_cyc_q.size() !== 1 || re_cyc_q[0] !== 1)
            $display("FAIL le_re: got %0d pulses first at %0d expected 1 at 1",
                     re_cyc_q.size(), re_cyc_q[0]);
        else n_pass++;
        n_checks++;
        if (first_v - re_cyc_q[0] !== 2)
            $display("FAIL le_latency: got %0d expected 2", first_v - re_cyc_q[0]);
        else n_pass++;
        n_checks++;
        if (bus_le.word_count !== 16'd1 || bus_le.busy !== 1'b0 || bus_le.tx_valid !== 1'b0)
            $display("FAIL le_after: got count %0d busy %b valid %b expected 1/0/0",
                     bus_le.word_count, bus_le.busy, bus_le.tx_valid);
        else n_pass++;
    endtask

    task automatic test_single_be();
        sel = 1'b1;
        set_ready_all();
        push_be(32'h11223344);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_bytes(4, 40);
        n_checks++;
        if (got_q.size() !== 4) $display("FAIL be_nbytes: got %0d expected 4", got_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3))
                $display("FAIL be_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (bus_be.word_count !== 16'd1 || bus_be.busy !== 1'b0)
            $display("FAIL be_after: got count %0d busy %b expected 1/0",
                     bus_be.word_count, bus_be.busy);
        else n_pass++;
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        do_reset();
        set_ready_all();
        push_le(32'hA0A1A2A3);
        push_le(32'hB0B1B2B3);
        push_le(32'hC0C1C2C3);
        exp_q = '{8'hA3, 8'hA2, 8'hA1, 8'hA0, 8'hB3, 8'hB2, 8'hB1, 8'hB0,
                  8'hC3, 8'hC2, 8'hC1, 8'hC0};
        run_bytes(12, 80);
        n_checks++;
        if (got_q.size() !== 12) $display("FAIL b2b_nbytes: got %0d expected 12", got_q.size());
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i % 4 == 3))
                $display("FAIL b2b_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i % 4 == 3));
            else n_pass++;
        end
        n_checks++;
        if (re_cyc_q.size() !== 3)
            $display("FAIL b2b_re_count: got %0d expected 3", re_cyc_q.size());
        else n_pass++;
        n_checks++;
        if (re_cyc_q[1] - re_cyc_q[0] !== 7 || re_cyc_q[2] - re_cyc_q[1] !== 7)
            $display("FAIL b2b_re_spacing: got %0d,%0d expected 7,7",
                     re_cyc_q[1] - re_cyc_q[0], re_cyc_q[2] - re_cyc_q[1]);
        else n_pass++;
        n_checks++;
        if (bus_le.word_count !== 16'd3)
            $display("FAIL b2b_count: got %0d expected 3", bus_le.word_count);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        push_le(32'h55667788);
        push_le(32'h99AABBCC);
        ready_pat[0] = 1'b1; ready_pat[1] = 1'b0; ready_pat[2] = 1'b0;
        ready_pat[3] = 1'b1; ready_pat[4] = 1'b0; ready_pat[5] = 1'b1;
        ready_len = 6;
        exp_q = '{8'h88, 8'h77, 8'h66, 8'h55};
        run_bytes(4, 60);
        n_checks++;
        if (got_q.size() !== 4) $display("FAIL bp_nbytes: got %0d expected 4", got_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3))
                $display("FAIL bp_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (stall_err !== 0) $display("FAIL bp_stable: got %0d changes expected 0", stall_err);
        else n_pass++;
        n_checks++;
        if (re_cyc_q.size() !== 1)
            $display("FAIL bp_re_count: got %0d expected 1", re_cyc_q.size());
        else n_pass++;
        n_checks++;
        if (bus_le.word_count !== 16'd4)
            $display("FAIL bp_count: got %0d expected 4", bus_le.word_count);
        else n_pass++;
        set_ready_all();
        exp_q = '{8'hCC, 8'hBB, 8'hAA, 8'h99};
        run_bytes(4, 40);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3))
                $display("FAIL bp2_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (bus_le.word_count !== 16'd5)
            $display("FAIL bp2_count: got %0d expected 5", bus_le.word_count);
        else n_pass++;
    endtask

    task automatic test_empty_idle();
        int errs;
        errs     = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 50; c++) begin
            step();
            if ({bus_le.fifo_re, bus_le.tx_valid, bus_le.busy,
                 bus_be.fifo_re, bus_be.tx_valid, bus_be.busy} !== 6'b000000) errs++;
        end
        tx_ready = 1'b0;
        n_checks++;
        if (errs !== 0) $display("FAIL empty_idle: got %0d active cycles expected 0", errs);
        else n_pass++;
        n_checks++;
        if (bad_re !== 0) $display("FAIL empty_read: got %0d reads on empty expected 0", bad_re);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int errs;
        sel = 1'b0;
        set_ready_all();
        push_le(32'hDEADBEEF);
        push_le(32'h01020304);
        run_bytes(2, 40);
        n_checks++;
        if (got_q.size() !== 2 || got_q[0] !== 8'hEF || got_q[1] !== 8'hBE)
            $display("FAIL ar_pre: got %0d bytes %h %h expected 2 bytes ef be",
                     got_q.size(), got_q[0], got_q[1]);
        else n_pass++;
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({bus_le.tx_valid, bus_le.busy, bus_le.fifo_re, bus_le.tx_last} !== 4'b0000)
            $display("FAIL ar_drop: got %b expected 0000",
                     {bus_le.tx_valid, bus_le.busy, bus_le.fifo_re, bus_le.tx_last});
        else n_pass++;
        n_checks++;
        if (bus_le.word_count !== 16'd0 || bus_be.word_count !== 16'd0 || bus_le.tx_data !== 8'h00)
            $display("FAIL ar_count: got le %0d be %0d data %h expected 0/0/00",
                     bus_le.word_count, bus_be.word_count, bus_le.tx_data);
        else n_pass++;
        errs = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus_le.fifo_re !== 1'b0 || dbg_le !== 2'd0) errs++;
        end
        n_checks++;
        if (errs !== 0) $display("FAIL ar_hold: got %0d active cycles expected 0", errs);
        else n_pass++;
        reset = 1'b0;
        exp_q = '{8'h04, 8'h03, 8'h02, 8'h01};
        run_bytes(4, 40);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i] || last_q[i] !== (i == 3))
                $display("FAIL ar_byte%0d: got %h last %b expected %h last %b",
                         i, got_q[i], last_q[i], exp_q[i], (i == 3));
            else n_pass++;
        end
        n_checks++;
        if (bus_le.word_count !== 16'd1 || bad_re !== 0)
            $display("FAIL ar_after: got count %0d bad reads %0d expected 1/0",
                     bus_le.word_count, bad_re);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_le();
        test_single_be();
        test_back_to_back();
        test_backpressure();
        test_empty_idle();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
